if_fetch_queue: RTL and testbench

Parametrised successor to the single-issue IF stage. It accepts fetch groups of up to FETCH_W instructions per cycle and tags fetch exceptions (ADEF, interrupt) per instruction. Entries are held in a DEPTH-entry circular queue and up to ISSUE_W instructions per cycle are presented to ID using the valid/allowin handshake. It sits between the pre-IF/instruction-RAM return path and the IF/ID boundary, and decouples fetch bandwidth from decode stalls.

---
 rtl/if_fetch_queue.sv | 119 +++++++++++
 tb/tb_if_fetch_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch-group circular queue between the instruction-RAM return and IF/ID
module if_fetch_queue #(
  parameter int PC_W     = 32,
  parameter int INST_W   = 32,
  parameter int EXC_W    = 17,
  parameter int INT_BIT  = 0,
  parameter int ADEF_BIT = 6,
  parameter int FETCH_W  = 2,
  parameter int ISSUE_W  = 2,
  parameter int DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               excep_flush_i,
  input  logic                               pi_valid_i,
  input  logic [PC_W-1:0]                    pi_pc_i,
  input  logic [FETCH_W-1:0]                 pi_slot_en_i,
  input  logic [FETCH_W*INST_W-1:0]          inst_i,
  input  logic                               interrupt_en_i,
  output logic                               if_allowin_o,
  input  logic                               id_allowin_i,
  output logic [ISSUE_W-1:0]                 if_to_id_valid_o,
  output logic [ISSUE_W*(PC_W+INST_W)-1:0]   pc_inst_obus,
  output logic [ISSUE_W*(1+EXC_W)-1:0]       to_ifid_obus,
  output logic [$clog2(DEPTH):0]             fq_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PI_W  = PC_W + INST_W;
  localparam int XB_W  = 1 + EXC_W;

  logic [PC_W-1:0]   r_pc       [DEPTH];
  logic [INST_W-1:0] r_inst     [DEPTH];
  logic              r_exc_en   [DEPTH];
  logic [EXC_W-1:0]  r_exc_type [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_blocked;

  logic [PC_W-1:0]    w_slot_pc   [FETCH_W];
  logic [EXC_W-1:0]   w_slot_type [FETCH_W];
  logic [FETCH_W-1:0] w_slot_exc;
  logic [FETCH_W-1:0] w_slot_wr;
  logic [CNT_W-1:0]   w_nenq;
  logic [CNT_W-1:0]   w_nenq_eff;
  logic [CNT_W-1:0]   w_ndeq;
  logic               w_stop;
  logic               w_enq;

  // Slots are taken in order up to and including the first excepting one.
  always_comb begin
    w_nenq    = '0;
    w_stop    = 1'b0;
    w_slot_wr = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      w_slot_pc[k]             = pi_pc_i + PC_W'(4 * k);
      w_slot_type[k]           = '0;
      w_slot_type[k][ADEF_BIT] = (w_slot_pc[k][1:0] != 2'b00);
      w_slot_type[k][INT_BIT]  = interrupt_en_i && (k == 0);
      w_slot_exc[k]            = w_slot_type[k][ADEF_BIT] || w_slot_type[k][INT_BIT];
      if (pi_slot_en_i[k] && !w_stop) begin
        w_slot_wr[k] = 1'b1;
        w_nenq       = w_nenq + CNT_W'(1);
        if (w_slot_exc[k]) begin
          w_stop = 1'b1;
        end
      end
    end
  end

  assign if_allowin_o = rst_n && !r_blocked && ((CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W));
  assign w_enq        = pi_valid_i && if_allowin_o && !excep_flush_i;
  assign w_nenq_eff   = w_enq ? w_nenq : '0;
  assign w_ndeq       = !id_allowin_i ? '0 :
                        ((r_count > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : r_count);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (w_slot_wr[k]) begin
          r_pc[r_tail + PTR_W'(k)]       <= w_slot_pc[k];
          r_inst[r_tail + PTR_W'(k)]     <= inst_i[k*INST_W +: INST_W];
          r_exc_en[r_tail + PTR_W'(k)]   <= w_slot_exc[k];
          r_exc_type[r_tail + PTR_W'(k)] <= w_slot_type[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || excep_flush_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_blocked <= 1'b0;
    end else begin
      r_head  <= r_head + w_ndeq[PTR_W-1:0];
      r_tail  <= r_tail + w_nenq_eff[PTR_W-1:0];
      r_count <= r_count + w_nenq_eff - w_ndeq;
      if (w_enq && w_stop) begin
        r_blocked <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_issue
    logic [PTR_W-1:0] w_rd_idx;
    assign w_rd_idx                        = r_head + PTR_W'(k);
    assign if_to_id_valid_o[k]             = rst_n && (r_count > CNT_W'(k));
    assign pc_inst_obus[k*PI_W +: PI_W]    = {r_pc[w_rd_idx], r_inst[w_rd_idx]};
    assign to_ifid_obus[k*XB_W +: XB_W]    = {r_exc_en[w_rd_idx], r_exc_type[w_rd_idx]};
  end

  assign fq_count_o = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed and random checks of if_fetch_queue against a queue model
module tb_if_fetch_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         excep_flush_i;
  logic         pi_valid_i;
  logic [31:0]  pi_pc_i;
  logic [1:0]   pi_slot_en_i;
  logic [63:0]  inst_i;
  logic         interrupt_en_i;
  logic         if_allowin_o;
  logic         id_allowin_i;
  logic [1:0]   if_to_id_valid_o;
  logic [127:0] pc_inst_obus;
  logic [35:0]  to_ifid_obus;
  logic [3:0]   fq_count_o;

  if_fetch_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .excep_flush_i    (excep_flush_i),
    .pi_valid_i       (pi_valid_i),
    .pi_pc_i          (pi_pc_i),
    .pi_slot_en_i     (pi_slot_en_i),
    .inst_i           (inst_i),
    .interrupt_en_i   (interrupt_en_i),
    .if_allowin_o     (if_allowin_o),
    .id_allowin_i     (id_allowin_i),
    .if_to_id_valid_o (if_to_id_valid_o),
    .pc_inst_obus     (pc_inst_obus),
    .to_ifid_obus     (to_ifid_obus),
    .fq_count_o       (fq_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        en;
    logic [16:0] typ;
  } ent_t;

  ent_t mq[$];
  logic m_blk;
  logic m_allow;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    m_allow = rst_n && !m_blk && (8 - n >= 2);
    chk("count", 64'(fq_count_o), 64'(n));
    chk("allowin", 64'(if_allowin_o), 64'(m_allow));
    for (int k = 0; k < 2; k++) begin
      chk("valid", 64'(if_to_id_valid_o[k]), 64'(rst_n && n > k));
      if (rst_n && n > k) begin
        chk("pc_inst", pc_inst_obus[k*64 +: 64], {mq[k].pc, mq[k].inst});
        chk("exc", 64'(to_ifid_obus[k*18 +: 18]), 64'({mq[k].en, mq[k].typ}));
      end
    end
  endtask

  task automatic model_update();
    int   nd;
    ent_t e;
    if (!rst_n || excep_flush_i) begin
      mq.delete();
      m_blk = 1'b0;
    end else begin
      nd = id_allowin_i ? ((mq.size() < 2) ? mq.size() : 2) : 0;
      repeat (nd) void'(mq.pop_front());
      if (pi_valid_i && m_allow) begin
        for (int k = 0; k < 2; k++) begin
          if (pi_slot_en_i[k]) begin
            e.pc   = pi_pc_i + 32'(4 * k);
            e.inst = inst_i[k*32 +: 32];
            e.typ  = '0;
            e.typ[6] = (e.pc[1:0] != 2'b00);
            e.typ[0] = interrupt_en_i && (k == 0);
            e.en   = e.typ[6] || e.typ[0];
            mq.push_back(e);
            if (e.en) begin
              m_blk = 1'b1;
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    #2;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [1:0] en, input logic idal);
    pi_valid_i   = pv;
    pi_pc_i      = pc;
    pi_slot_en_i = en;
    id_allowin_i = idal;
    inst_i       = {$urandom(), $urandom()};
  endtask

  logic [31:0] base;

  initial begin
    rst_n = 1'b0; excep_flush_i = 1'b0; interrupt_en_i = 1'b0;
    drive(1'b1, 32'h1c00_0000, 2'b11, 1'b0);
    m_blk = 1'b0;
    @(posedge clk); #1;
    // Reset held with a valid group presented
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h1c00_0000, 2'b11, 1'b0);
    #1;
    chk("t1_allow", 64'(if_allowin_o), 64'd1);
    chk("t1_count", 64'(fq_count_o), 64'd0);
    step();

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1c00_0000 + 32'(8 * i), 2'b11, 1'b0);
      step();
    end
    chk("t2_count8", 64'(fq_count_o), 64'd8);
    chk("t2_allow0", 64'(if_allowin_o), 64'd0);
    drive(1'b0, 32'h0, 2'b11, 1'b1);
    #1;
    chk("t2_pc0", 64'(pc_inst_obus[63:32]), 64'h1c00_0000);
    chk("t2_pc1", 64'(pc_inst_obus[127:96]), 64'h1c00_0004);
    step();
    chk("t2_count6", 64'(fq_count_o), 64'd6);

    excep_flush_i = 1'b1; drive(1'b0, 32'h0, 2'b11, 1'b0); step();
    excep_flush_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1c00_0100 + 32'(8 * i), 2'b11, 1'b1);
      step();
    end
    chk("t3_count2", 64'(fq_count_o), 64'd2);

    excep_flush_i = 1'b1; drive(1'b0, 32'h0, 2'b11, 1'b0); step();
    excep_flush_i = 1'b0;
    drive(1'b1, 32'h1c00_0002, 2'b11, 1'b0); step();
    drive(1'b1, 32'h1c00_0008, 2'b11, 1'b0);
    chk("t4_count1", 64'(fq_count_o), 64'd1);
    chk("t4_exc", 64'(to_ifid_obus[17:0]), 64'({1'b1, 17'h0040}));
    step(); step();
    chk("t4_blocked", 64'(if_allowin_o), 64'd0);
    excep_flush_i = 1'b1; step();
    excep_flush_i = 1'b0; drive(1'b0, 32'h0, 2'b11, 1'b0);
    #1;
    chk("t4_cnt0", 64'(fq_count_o), 64'd0);
    chk("t4_allow1", 64'(if_allowin_o), 64'd1);
    step();

    interrupt_en_i = 1'b1;
    drive(1'b1, 32'h1c00_0010, 2'b11, 1'b0); step();
    interrupt_en_i = 1'b0; drive(1'b0, 32'h0, 2'b11, 1'b0);
    #1;
    chk("t5_count1", 64'(fq_count_o), 64'd1);
    chk("t5_exc", 64'(to_ifid_obus[17:0]), 64'({1'b1, 17'h00001}));
    chk("t5_blocked", 64'(if_allowin_o), 64'd0);
    step();
    excep_flush_i = 1'b1; step(); excep_flush_i = 1'b0;

    drive(1'b1, 32'h1c00_0200, 2'b11, 1'b0); step();
    drive(1'b1, 32'h1c00_0208, 2'b11, 1'b0); step();
    drive(1'b1, 32'h1c00_0210, 2'b01, 1'b0); step();
    chk("t6_count5", 64'(fq_count_o), 64'd5);
    excep_flush_i = 1'b1; drive(1'b1, 32'h1c00_0218, 2'b11, 1'b1); step();
    excep_flush_i = 1'b0; drive(1'b1, 32'h1c00_0300, 2'b01, 1'b0);
    #1;
    chk("t6_count0", 64'(fq_count_o), 64'd0);
    chk("t6_valid0", 64'(if_to_id_valid_o), 64'd0);
    step();
    drive(1'b0, 32'h0, 2'b11, 1'b0);
    #1;
    chk("t6_count1", 64'(fq_count_o), 64'd1);
    chk("t6_valid1", 64'(if_to_id_valid_o), 64'd1);
    step();

    // Random traffic: misaligned PCs, interrupts, flushes, stalls, occasional reset
    base = 32'h1c00_1000;
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      excep_flush_i  = (m_blk && $urandom_range(0, 3) == 0) || ($urandom_range(0, 29) == 0);
      interrupt_en_i = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 24) == 0) ? (base | 32'h2) : base,
            ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11,
            $urandom_range(0, 2) != 0);
      base = base + 32'd8;
      step();
    end
    rst_n = 1'b1; excep_flush_i = 1'b0; interrupt_en_i = 1'b0;
    drive(1'b0, 32'h0, 2'b11, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
